// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the integer pipeline.
// Imported by the writeback/register-file slice.
package cpu_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: async active-low clear, one write port,
// two combinational read ports, register 0 hardwired to zero.
module regfile_core
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int NREGS  = cpu_pkg::NREGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);
   localparam logic [ADDR_W-1:0] LP_ZERO = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic              w_wr;

   assign w_wr = i_we && (i_waddr != LP_ZERO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Index 0 is masked at the read mux so it can never leak a value.
   assign o_rdata1 = (i_raddr1 == LP_ZERO) ? '0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == LP_ZERO) ? '0 : r_regs[i_raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result mux, register commit, read ports, write counter.
// Define WB_BYPASS_EN for same-cycle write-to-read bypass.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int NREGS  = cpu_pkg::NREGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_MemToReg,
   input  logic              wb_RegWrite,
   input  logic [DATA_W-1:0] MemRes,
   input  logic [DATA_W-1:0] ALURes,
   input  logic [ADDR_W-1:0] RegDest,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       WrCount
);
   localparam logic [ADDR_W-1:0] LP_ZERO = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_commit;
   logic [31:0]       r_wrcount;

   assign w_wdata   = wb_MemToReg ? MemRes : ALURes;
   assign WriteData = w_wdata;

   // RegWrite gates first so X on RegDest cannot leak into state.
   assign w_commit = wb_RegWrite && (RegDest != LP_ZERO);

   regfile_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_commit),
      .i_waddr  (RegDest),
      .i_wdata  (w_wdata),
      .i_raddr1 (ReadReg1),
      .i_raddr2 (ReadReg2),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2)
   );

`ifdef WB_BYPASS_EN
   assign ReadData1 = (w_commit && ReadReg1 == RegDest) ? w_wdata : w_rd1;
   assign ReadData2 = (w_commit && ReadReg2 == RegDest) ? w_wdata : w_rd2;
`else
   assign ReadData1 = w_rd1;
   assign ReadData2 = w_rd2;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrcount <= '0;
      end else if (w_commit) begin
         r_wrcount <= r_wrcount + 32'd1;
      end
   end

   assign WrCount = r_wrcount;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// Expectations follow WB_BYPASS_EN when the bench is built with it.
module tb_wb_regfile;
   import cpu_pkg::*;

   logic     clk;
   logic     rst;
   logic     wb_MemToReg;
   logic     wb_RegWrite;
   word_t    MemRes;
   word_t    ALURes;
   reg_idx_t RegDest;
   reg_idx_t ReadReg1;
   reg_idx_t ReadReg2;
   word_t    ReadData1;
   word_t    ReadData2;
   word_t    WriteData;
   logic [31:0] WrCount;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .wb_MemToReg (wb_MemToReg),
      .wb_RegWrite (wb_RegWrite),
      .MemRes      (MemRes),
      .ALURes      (ALURes),
      .RegDest     (RegDest),
      .ReadReg1    (ReadReg1),
      .ReadReg2    (ReadReg2),
      .ReadData1   (ReadData1),
      .ReadData2   (ReadData2),
      .WriteData   (WriteData),
      .WrCount     (WrCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one committed-write attempt, step past the edge, then idle.
   task automatic wb_write(input logic m2r, input word_t mem,
                           input word_t alu, input reg_idx_t dest);
      @(negedge clk);
      wb_MemToReg = m2r;
      MemRes      = mem;
      ALURes      = alu;
      RegDest     = dest;
      wb_RegWrite = 1'b1;
      @(posedge clk);
      #1;
      wb_RegWrite = 1'b0;
   endtask

   initial begin
      rst         = 1'b0;
      wb_MemToReg = 1'b0;
      wb_RegWrite = 1'b0;
      MemRes      = '0;
      ALURes      = '0;
      RegDest     = '0;
      ReadReg1    = 5'd7;
      ReadReg2    = 5'd8;
      #2;
      chk("rst_count", WrCount, 32'd0);
      chk("rst_rd1", ReadData1, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // MemToReg=1 picks load data
      @(negedge clk);
      wb_MemToReg = 1'b1;
      MemRes      = 32'hDEADBEEF;
      ALURes      = 32'h12345678;
      RegDest     = 5'd7;
      wb_RegWrite = 1'b1;
      #1;
      chk("sel_mem", WriteData, 32'hDEADBEEF);
      chk("pre_edge_r7", ReadData1, BYP ? 32'hDEADBEEF : 32'h0);
      @(posedge clk);
      #1;
      wb_RegWrite = 1'b0;
      #1;
      chk("r7", ReadData1, 32'hDEADBEEF);
      chk("cnt1", WrCount, 32'd1);

      wb_write(1'b0, 32'hDEADBEEF, 32'h12345678, 5'd8);
      #1;
      chk("sel_alu", WriteData, 32'h12345678);
      chk("r8", ReadData2, 32'h12345678);
      chk("cnt2", WrCount, 32'd2);
      ReadReg1 = 5'd8;
      #1;
      chk("dual_r8", ReadData1, 32'h12345678);

      // Register 0 discards writes
      ReadReg1 = 5'd0;
      wb_write(1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
      #1;
      chk("r0_read", ReadData1, 32'h0);
      chk("r0_count", WrCount, 32'd2);

      wb_write(1'b0, 32'h0, 32'h11111111, 5'd5);
      @(negedge clk);
      ReadReg2    = 5'd5;
      wb_MemToReg = 1'b0;
      ALURes      = 32'hA5A5A5A5;
      RegDest     = 5'd5;
      wb_RegWrite = 1'b1;
      #1;
      chk("byp_r5", ReadData2, BYP ? 32'hA5A5A5A5 : 32'h11111111);
      @(posedge clk);
      #1;
      wb_RegWrite = 1'b0;
      #1;
      chk("post_r5", ReadData2, 32'hA5A5A5A5);
      chk("cnt4", WrCount, 32'd4);

      // Disabled write with X data
      wb_write(1'b1, 32'h33333333, 32'h0, 5'd3);
      ReadReg1 = 5'd3;
      @(negedge clk);
      wb_MemToReg = 1'bx;
      MemRes      = 'x;
      ALURes      = 'x;
      RegDest     = 5'd3;
      wb_RegWrite = 1'b0;
      #1;
      chk("nowr_pre", ReadData1, 32'h33333333);
      @(posedge clk);
      #1;
      chk("nowr_r3", ReadData1, 32'h33333333);
      chk("nowr_cnt", WrCount, 32'd5);

      // Reset beats a pending write and clears without an edge
      @(negedge clk);
      wb_MemToReg = 1'b0;
      ALURes      = 32'h99999999;
      RegDest     = 5'd9;
      wb_RegWrite = 1'b1;
      ReadReg1    = 5'd7;
      ReadReg2    = 5'd5;
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_rd1", ReadData1, 32'h0);
      chk("mid_rst_rd2", ReadData2, 32'h0);
      chk("mid_rst_cnt", WrCount, 32'd0);
      @(posedge clk);
      #1;
      wb_RegWrite = 1'b0;
      ReadReg1    = 5'd9;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("lost_r9", ReadData1, 32'h0);
      chk("lost_cnt", WrCount, 32'd0);

      // Counter wrap
      @(negedge clk);
      force dut.r_wrcount = 32'hFFFFFFFF;
      #1;
      chk("preload", WrCount, 32'hFFFFFFFF);
      release dut.r_wrcount;
      wb_write(1'b0, 32'h0, 32'h0000000A, 5'd10);
      #1;
      chk("wrap", WrCount, 32'd0);
      wb_write(1'b1, 32'h0000000B, 32'h0, 5'd11);
      #1;
      chk("after_wrap", WrCount, 32'd1);
      ReadReg2 = 5'd11;
      #1;
      chk("r11", ReadData2, 32'h0000000B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
